instr_fetch_unit: RTL and testbench

- Fetch stage upstream of the instruction decoder. Replaces the flat instruction-memory lookup with a real fetch path to lower memory.
- Generates sequential fetch addresses and issues word requests over a valid/ready request channel.
- Collects in-order responses into a prefetch queue and presents one instruction per cycle to decode over a valid/ready handshake.
- Handles PC redirects from branch/jump resolution by flushing the queue and discarding stale in-flight responses.

---
 rtl/riscv_pkg.sv | 18 +
 rtl/fetch_queue.sv | 67 ++++++
 rtl/instr_fetch_unit.sv | 148 ++++++++++++++
 tb/tb_instr_fetch_unit.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared fetch-path types and constants: datapath widths, default reset PC,
// fetch FSM state encoding and the prefetch queue entry layout.
package riscv_pkg;
    localparam int unsigned XLEN        = 32;
    localparam int unsigned ILEN        = 32;
    localparam int unsigned INSTR_BYTES = 4;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic {
        IFU_RUN   = 1'b0,
        IFU_FLUSH = 1'b1
    } ifu_state_t;

    typedef struct packed {
        logic [ILEN-1:0] instr;
        logic [XLEN-1:0] addr;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// Synchronous prefetch FIFO of fetch entries; flush has priority over push/pop.
// Push and pop may coincide at any occupancy, including full and empty.
module fetch_queue
    import riscv_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  fetch_entry_t           push_data,
    input  logic                   pop,
    input  logic                   flush,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output fetch_entry_t           head_c
);
    localparam int unsigned AW = $clog2(DEPTH);

    fetch_entry_t          slots [DEPTH];
    logic [AW-1:0]         rd_ptr;
    logic [AW-1:0]         wr_ptr;
    logic [AW:0]           count_n;
    logic                  do_push;
    logic                  do_pop;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head_c  = slots[rd_ptr];

    always_comb begin
        count_n = count;
        if (do_push && !do_pop) begin
            count_n = count + (AW+1)'(1);
        end else if (!do_push && do_pop) begin
            count_n = count - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count_n;
            empty <= (count_n == '0);
            full  <= (count_n == (AW+1)'(DEPTH));
        end
    end

    // Storage needs no reset: it is only ever read behind a non-empty head.
    always_ff @(posedge clk) begin
        if (do_push && !flush) slots[wr_ptr] <= push_data;
    end
endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: credit-limited sequential word requests, in-order response capture
// into a prefetch queue, redirect flush with stale-response dropping.
// Optional macro IFU_PERF_CNT_EN adds stall_cycles / redirect_count ports.
module instr_fetch_unit
    import riscv_pkg::*;
#(
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
`ifdef IFU_PERF_CNT_EN
    output logic [31:0]     stall_cycles,
    output logic [31:0]     redirect_count,
`endif
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [XLEN-1:0] mem_req_addr,
    input  logic            mem_resp_valid,
    input  logic [ILEN-1:0] mem_resp_data,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [ILEN-1:0] instr,
    output logic [XLEN-1:0] instr_addr
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    ifu_state_t      state;
    ifu_state_t      state_n;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] pc_in;
    logic [XLEN-1:0] redirect_base;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   outstanding_n;
    logic [CW-1:0]   drop;
    logic [CW-1:0]   drop_n;
    logic [CW+1:0]   credit_used;
    logic            stage_valid;
    fetch_entry_t    stage_entry;
    logic            req_fire;
    logic            resp_take;
    logic [CW-1:0]   q_count;
    logic            q_full;
    logic            q_empty;
    fetch_entry_t    q_head;
    logic            unused_pc_lsbs;

    assign redirect_base  = {redirect_pc[XLEN-1:2], 2'b00};
    assign unused_pc_lsbs = ^redirect_pc[1:0];

    // Captured-but-unpushed responses hold a credit just like queued entries.
    assign credit_used   = (CW+2)'(q_count) + (CW+2)'(stage_valid) + (CW+2)'(outstanding);
    assign mem_req_valid = reset && !redirect_valid && (credit_used < (CW+2)'(DEPTH));
    assign mem_req_addr  = fetch_pc;
    assign req_fire      = mem_req_valid && mem_req_ready;
    assign resp_take     = mem_resp_valid && !redirect_valid && (drop == '0);

    assign instr_valid = !q_empty;
    assign instr       = instr_valid ? q_head.instr : '0;
    assign instr_addr  = instr_valid ? q_head.addr  : '0;

    fetch_queue #(.DEPTH(DEPTH)) u_queue (
        .clk       (clk),
        .rst_n     (reset),
        .push      (stage_valid),
        .push_data (stage_entry),
        .pop       (instr_valid && instr_ready),
        .flush     (redirect_valid),
        .full      (q_full),
        .empty     (q_empty),
        .count     (q_count),
        .head_c    (q_head)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IFU_RUN;
            outstanding <= '0;
            drop        <= '0;
        end else begin
            state       <= state_n;
            outstanding <= outstanding_n;
            drop        <= drop_n;
        end
    end

    // On redirect every request still in flight becomes stale.
    always_comb begin
        state_n       = state;
        outstanding_n = outstanding;
        drop_n        = drop;
        if (req_fire && !mem_resp_valid) begin
            outstanding_n = outstanding + CW'(1);
        end else if (!req_fire && mem_resp_valid) begin
            outstanding_n = outstanding - CW'(1);
        end
        if (redirect_valid) begin
            drop_n  = outstanding_n;
            state_n = (outstanding_n != '0) ? IFU_FLUSH : IFU_RUN;
        end else begin
            if (mem_resp_valid && (drop != '0)) drop_n = drop - CW'(1);
            if ((state == IFU_FLUSH) && (drop_n == '0)) state_n = IFU_RUN;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc    <= RESET_PC;
            pc_in       <= RESET_PC;
            stage_valid <= 1'b0;
            stage_entry <= '0;
        end else if (redirect_valid) begin
            fetch_pc    <= redirect_base;
            pc_in       <= redirect_base;
            stage_valid <= 1'b0;
        end else begin
            if (req_fire) fetch_pc <= fetch_pc + XLEN'(INSTR_BYTES);
            stage_valid <= resp_take;
            if (resp_take) begin
                stage_entry <= '{instr: mem_resp_data, addr: pc_in};
                pc_in       <= pc_in + XLEN'(INSTR_BYTES);
            end
        end
    end

`ifdef IFU_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cycles   <= '0;
            redirect_count <= '0;
        end else begin
            if (!instr_valid && instr_ready && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + 32'(1);
            end
            if (redirect_valid && (redirect_count != '1)) begin
                redirect_count <= redirect_count + 32'(1);
            end
        end
    end
`endif

    a_resp_has_credit: assert property (@(posedge clk) disable iff (!reset)
        mem_resp_valid |-> (outstanding != '0));
    a_no_overfill: assert property (@(posedge clk) disable iff (!reset)
        !(q_full && stage_valid));
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a fixed-latency in-order memory model.
module tb_instr_fetch_unit;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic [31:0] mem_req_addr;
    logic        mem_resp_valid = 1'b0;
    logic [31:0] mem_resp_data = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [31:0] instr_addr;
`ifdef IFU_PERF_CNT_EN
    logic [31:0] stall_cycles;
    logic [31:0] redirect_count;
`endif

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int lat   = 1;
    logic [31:0] pend_addr [$];
    int          pend_due  [$];
    logic [31:0] req_log   [$];
    logic [31:0] got_addr  [$];
    logic [31:0] got_instr [$];

    always #5 clk = ~clk;

    instr_fetch_unit #(.DEPTH(4), .RESET_PC(32'h0000_0000)) u_dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
`ifdef IFU_PERF_CNT_EN
        .stall_cycles   (stall_cycles),
        .redirect_count (redirect_count),
`endif
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_addr     (instr_addr)
    );

    // One clock of stimulus; memory returns data = addr + 0x1000 after lat cycles.
    task automatic drive_cycle(input logic rdv, input logic [31:0] rpc,
                               input logic ird, input logic mrdy);
        @(negedge clk);
        redirect_valid = rdv;
        redirect_pc    = rpc;
        instr_ready    = ird;
        mem_req_ready  = mrdy;
        if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = pend_addr[0] + 32'h1000;
            void'(pend_addr.pop_front());
            void'(pend_due.pop_front());
        end else begin
            mem_resp_valid = 1'b0;
            mem_resp_data  = '0;
        end
        #1;
        if (mem_req_valid && mem_req_ready) begin
            pend_addr.push_back(mem_req_addr);
            pend_due.push_back(cyc + lat);
            req_log.push_back(mem_req_addr);
        end
        if (instr_valid && instr_ready) begin
            got_addr.push_back(instr_addr);
            got_instr.push_back(instr);
        end
        cyc++;
    endtask

    task automatic clear_logs();
        pend_addr.delete();
        pend_due.delete();
        req_log.delete();
        got_addr.delete();
        got_instr.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        redirect_valid = 1'b0;
        mem_req_ready = 1'b0;
        mem_resp_valid = 1'b0;
        instr_ready = 1'b0;
        clear_logs();
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        #1;
        total++; if (mem_req_valid !== 1'b0) begin bad++; $display("FAIL reset_req_valid got=%b exp=0", mem_req_valid); end
        total++; if (mem_req_addr !== 32'h0) begin bad++; $display("FAIL reset_req_addr got=%h exp=00000000", mem_req_addr); end
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL reset_instr_valid got=%b exp=0", instr_valid); end
        total++; if (instr !== 32'h0) begin bad++; $display("FAIL reset_instr got=%h exp=00000000", instr); end
        total++; if (instr_addr !== 32'h0) begin bad++; $display("FAIL reset_instr_addr got=%h exp=00000000", instr_addr); end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_stream();
        lat = 1;
        clear_logs();
        for (int k = 0; k < 12; k++) drive_cycle(1'b0, '0, 1'b1, 1'b1);
        total++; if (req_log.size() != 12) begin bad++; $display("FAIL stream_req_count got=%0d exp=12", req_log.size()); end
        total++; if (got_addr.size() != 9) begin bad++; $display("FAIL stream_pop_count got=%0d exp=9", got_addr.size()); end
        for (int i = 0; i < 8; i++) begin
            total++;
            if (req_log.size() <= i || req_log[i] !== 32'(4*i)) begin
                bad++; $display("FAIL stream_req_addr[%0d] got=%h exp=%h", i, req_log[i], 32'(4*i));
            end
            total++;
            if (got_addr.size() <= i || got_addr[i] !== 32'(4*i) || got_instr[i] !== 32'(32'h1000 + 4*i)) begin
                bad++; $display("FAIL stream_instr[%0d] got=%h@%h exp=%h@%h", i, got_instr[i], got_addr[i],
                                32'(32'h1000 + 4*i), 32'(4*i));
            end
        end
    endtask

    task automatic test_backpressure();
        logic v_pop;
        logic v_next;
        logic [31:0] a_next;
        do_reset();
        lat = 1;
        for (int k = 0; k < 10; k++) drive_cycle(1'b0, '0, 1'b0, 1'b1);
        total++; if (req_log.size() != 4) begin bad++; $display("FAIL bp_req_count got=%0d exp=4", req_log.size()); end
        total++; if (mem_req_valid !== 1'b0) begin bad++; $display("FAIL bp_full_req_valid got=%b exp=0", mem_req_valid); end
        total++; if (instr_valid !== 1'b1 || instr_addr !== 32'h0) begin bad++; $display("FAIL bp_head got=%b@%h exp=1@00000000", instr_valid, instr_addr); end
        drive_cycle(1'b0, '0, 1'b1, 1'b1);
        v_pop = mem_req_valid;
        drive_cycle(1'b0, '0, 1'b0, 1'b1);
        v_next = mem_req_valid;
        a_next = mem_req_addr;
        total++; if (got_addr.size() != 1) begin bad++; $display("FAIL bp_single_pop got=%0d exp=1", got_addr.size()); end
        total++; if (v_pop !== 1'b0) begin bad++; $display("FAIL bp_pop_cycle_req got=%b exp=0", v_pop); end
        total++; if (v_next !== 1'b1 || a_next !== 32'h10) begin bad++; $display("FAIL bp_next_req got=%b@%h exp=1@00000010", v_next, a_next); end
        for (int k = 0; k < 8; k++) drive_cycle(1'b0, '0, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            total++;
            if (got_addr.size() <= i || got_addr[i] !== 32'(4*i) || got_instr[i] !== 32'(32'h1000 + 4*i)) begin
                bad++; $display("FAIL bp_order[%0d] got=%h@%h exp=%h@%h", i, got_instr[i], got_addr[i],
                                32'(32'h1000 + 4*i), 32'(4*i));
            end
        end
    endtask

    task automatic test_redirect();
        logic v_red;
        do_reset();
        lat = 3;
        drive_cycle(1'b0, '0, 1'b1, 1'b1);
        drive_cycle(1'b0, '0, 1'b1, 1'b1);
        drive_cycle(1'b1, 32'h0000_0102, 1'b1, 1'b1);
        v_red = mem_req_valid;
        drive_cycle(1'b0, '0, 1'b1, 1'b1);
        total++; if (u_dut.state !== IFU_FLUSH) begin bad++; $display("FAIL redir_state_flush got=%0d exp=%0d", u_dut.state, IFU_FLUSH); end
        drive_cycle(1'b0, '0, 1'b1, 1'b1);
        drive_cycle(1'b0, '0, 1'b1, 1'b1);
        total++; if (u_dut.state !== IFU_RUN) begin bad++; $display("FAIL redir_state_run got=%0d exp=%0d", u_dut.state, IFU_RUN); end
        for (int k = 0; k < 9; k++) drive_cycle(1'b0, '0, 1'b1, 1'b1);
        total++; if (v_red !== 1'b0) begin bad++; $display("FAIL redir_req_valid got=%b exp=0", v_red); end
        total++; if (req_log.size() < 3 || req_log[2] !== 32'h100) begin bad++; $display("FAIL redir_req_addr got=%h exp=00000100", req_log[2]); end
        total++; if (got_addr.size() < 3) begin bad++; $display("FAIL redir_pop_count got=%0d exp>=3", got_addr.size()); end
        for (int i = 0; i < 3; i++) begin
            total++;
            if (got_addr.size() <= i || got_addr[i] !== 32'(32'h100 + 4*i) || got_instr[i] !== 32'(32'h1100 + 4*i)) begin
                bad++; $display("FAIL redir_instr[%0d] got=%h@%h exp=%h@%h", i, got_instr[i], got_addr[i],
                                32'(32'h1100 + 4*i), 32'(32'h100 + 4*i));
            end
        end
    endtask

    task automatic test_redirect_with_resp();
        logic v_red;
        do_reset();
        lat = 2;
        drive_cycle(1'b0, '0, 1'b1, 1'b1);
        drive_cycle(1'b0, '0, 1'b1, 1'b1);
        drive_cycle(1'b1, 32'h0000_0200, 1'b1, 1'b1);
        v_red = mem_req_valid;
        drive_cycle(1'b0, '0, 1'b1, 1'b1);
        total++; if (u_dut.state !== IFU_FLUSH) begin bad++; $display("FAIL rresp_state_flush got=%0d exp=%0d", u_dut.state, IFU_FLUSH); end
        drive_cycle(1'b0, '0, 1'b1, 1'b1);
        total++; if (u_dut.state !== IFU_RUN) begin bad++; $display("FAIL rresp_state_run got=%0d exp=%0d", u_dut.state, IFU_RUN); end
        for (int k = 0; k < 6; k++) drive_cycle(1'b0, '0, 1'b1, 1'b1);
        total++; if (v_red !== 1'b0) begin bad++; $display("FAIL rresp_req_valid got=%b exp=0", v_red); end
        for (int i = 0; i < 2; i++) begin
            total++;
            if (got_addr.size() <= i || got_addr[i] !== 32'(32'h200 + 4*i) || got_instr[i] !== 32'(32'h1200 + 4*i)) begin
                bad++; $display("FAIL rresp_instr[%0d] got=%h@%h exp=%h@%h", i, got_instr[i], got_addr[i],
                                32'(32'h1200 + 4*i), 32'(32'h200 + 4*i));
            end
        end
    endtask

    task automatic test_wrap_and_async_reset();
        logic [31:0] exp_a [3];
        logic [31:0] exp_d [3];
        exp_a[0] = 32'hFFFF_FFF8; exp_a[1] = 32'hFFFF_FFFC; exp_a[2] = 32'h0000_0000;
        exp_d[0] = 32'h0000_0FF8; exp_d[1] = 32'h0000_0FFC; exp_d[2] = 32'h0000_1000;
        do_reset();
        lat = 1;
        drive_cycle(1'b1, 32'hFFFF_FFF8, 1'b1, 1'b1);
        for (int k = 0; k < 7; k++) drive_cycle(1'b0, '0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            total++;
            if (req_log.size() <= i || req_log[i] !== exp_a[i]) begin
                bad++; $display("FAIL wrap_req[%0d] got=%h exp=%h", i, req_log[i], exp_a[i]);
            end
            total++;
            if (got_addr.size() <= i || got_addr[i] !== exp_a[i] || got_instr[i] !== exp_d[i]) begin
                bad++; $display("FAIL wrap_instr[%0d] got=%h@%h exp=%h@%h", i, got_instr[i], got_addr[i], exp_d[i], exp_a[i]);
            end
        end
        #2;
        reset = 1'b0;
        mem_resp_valid = 1'b0;
        mem_req_ready = 1'b0;
        #1;
        total++; if (mem_req_valid !== 1'b0) begin bad++; $display("FAIL async_req_valid got=%b exp=0", mem_req_valid); end
        total++; if (mem_req_addr !== 32'h0) begin bad++; $display("FAIL async_req_addr got=%h exp=00000000", mem_req_addr); end
        total++; if (instr_valid !== 1'b0 || instr !== 32'h0 || instr_addr !== 32'h0) begin
            bad++; $display("FAIL async_instr got=%b %h@%h exp=0 00000000@00000000", instr_valid, instr, instr_addr);
        end
        clear_logs();
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 6; k++) drive_cycle(1'b0, '0, 1'b1, 1'b1);
        total++; if (req_log.size() < 1 || req_log[0] !== 32'h0) begin bad++; $display("FAIL restart_req got=%h exp=00000000", req_log[0]); end
        total++; if (got_addr.size() < 1 || got_addr[0] !== 32'h0 || got_instr[0] !== 32'h1000) begin
            bad++; $display("FAIL restart_instr got=%h@%h exp=00001000@00000000", got_instr[0], got_addr[0]);
        end
    endtask

`ifdef IFU_PERF_CNT_EN
    task automatic test_perf();
        do_reset();
        for (int k = 0; k < 5; k++) drive_cycle(1'b0, '0, 1'b1, 1'b0);
        drive_cycle(1'b1, 32'h40, 1'b0, 1'b0);
        drive_cycle(1'b1, 32'h80, 1'b0, 1'b0);
        drive_cycle(1'b0, '0, 1'b0, 1'b0);
        total++; if (stall_cycles !== 32'd5) begin bad++; $display("FAIL perf_stall got=%0d exp=5", stall_cycles); end
        total++; if (redirect_count !== 32'd2) begin bad++; $display("FAIL perf_redirect got=%0d exp=2", redirect_count); end
    endtask
`endif

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_redirect_with_resp();
        test_wrap_and_async_reset();
`ifdef IFU_PERF_CNT_EN
        test_perf();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
